// File: rtl/ssd1306_i2c_writer.sv
// ssd1306_i2c_writer: write-only I2C master sending one (control, data) byte pair per request to an SSD1306
module ssd1306_i2c_writer #(
  parameter int         CLK_FREQ_HZ = 32_000_000,
  parameter int         SCL_FREQ_HZ = 400_000,
  parameter logic [6:0] DEV_ADDR    = 7'h3C,
  parameter int         CLK_DIV     = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ)
) (
  input  logic       clk_32M,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] reg_addr,
  input  logic [7:0] data_in,
  output logic       done,
  output logic       busy,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);
  if (CLK_DIV < 2) begin : g_div_chk
    $error("CLK_DIV must be at least 2");
  end
  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, START, BYTE, STOP, BUF} state_t;
  state_t        state;
  logic [QW-1:0] qcnt;
  logic [1:0]    quarter;
  logic [3:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   sh;
  logic          sda_lo, sda_s1, sda_s2, nack;
  logic          scl_d, sda_lo_d, q_last, slot_end;
  assign sda      = sda_lo ? 1'b0 : 1'bz;
  assign q_last   = qcnt == QW'(CLK_DIV - 1);
  assign slot_end = q_last && quarter == 2'd3;
  // Bus levels for the current slot position; registered, so the pins trail the state by one cycle
  always_comb begin
    scl_d    = 1'b1;
    sda_lo_d = 1'b0;
    case (state)
      START: sda_lo_d = quarter[1];
      BYTE: begin
        scl_d    = quarter[1];
        sda_lo_d = quarter == 2'd0 ? sda_lo : (bit_idx != 4'd0 && !sh[23]);
      end
      STOP: begin
        scl_d    = quarter[1];
        sda_lo_d = quarter == 2'd0 ? sda_lo : quarter != 2'd3;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_32M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      qcnt     <= '0;
      quarter  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      sh       <= '0;
      sda_lo   <= 1'b0;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      nack     <= 1'b0;
      scl      <= 1'b1;
      done     <= 1'b0;
      busy     <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
      done   <= 1'b0;
      scl    <= scl_d;
      sda_lo <= sda_lo_d;
      if (state == IDLE) begin
        if (enable) begin
          sh    <= {DEV_ADDR, 1'b0, reg_addr, data_in};
          nack  <= 1'b0;
          busy  <= 1'b1;
          state <= START;
        end
      end else begin
        qcnt <= q_last ? '0 : qcnt + 1'b1;
        if (q_last)
          quarter <= quarter + 1'b1;
        if (slot_end)
          case (state)
            START: begin
              state    <= BYTE;
              bit_idx  <= 4'd8;
              byte_idx <= 2'd0;
            end
            BYTE:
              if (bit_idx != 4'd0) begin
                bit_idx <= bit_idx - 1'b1;
                sh      <= sh << 1;
              end else if (sda_s2 || byte_idx == 2'd2) begin
                nack  <= sda_s2;
                state <= STOP;
              end else begin
                bit_idx  <= 4'd8;
                byte_idx <= byte_idx + 1'b1;
              end
            STOP: begin
              state   <= BUF;
              done    <= 1'b1;
              ack_err <= nack;
            end
            default: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          endcase
      end
    end
  end
endmodule

// File: tb/tb_ssd1306_i2c_writer.sv
// tb_ssd1306_i2c_writer: bus-level slave/decoder with a transaction-level reference model
module tb_ssd1306_i2c_writer;
  localparam int QB = 20;
  localparam int SLOT = 4 * QB;
  logic       clk_32M = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [7:0] reg_addr = 8'h00, data_in = 8'h00;
  logic       done, busy, ack_err, scl;
  logic       slave_lo = 1'b0;
  wire        sda;
  pullup (sda);
  assign sda = slave_lo ? 1'b0 : 1'bz;
  always #5 clk_32M = ~clk_32M;

  ssd1306_i2c_writer dut (
    .clk_32M(clk_32M), .rst_n(rst_n), .enable(enable), .reg_addr(reg_addr), .data_in(data_in),
    .done(done), .busy(busy), .ack_err(ack_err), .scl(scl), .sda(sda)
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0, rise_cnt = 0, rise_cyc = 0, done_cnt = 0, done_cyc = 0;
  int n_stop = 0, period_bad = 0, bad_change = 0, nack_at = 3, bitcnt = 0, last_rise = -1;
  logic busy_q = 1'b0, scl_q = 1'b1, sda_q = 1'b1, in_txn = 1'b0, prev_err = 1'b0;
  logic [7:0] shv = 8'h00;
  logic [7:0] rx[$];

  // Monitor plus slave: decodes START/STOP/bytes, ACKs every byte except index nack_at
  always @(negedge clk_32M) begin
    cyc++;
    if (busy && !busy_q) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    busy_q = busy;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (!rst_n) begin
      in_txn   = 1'b0;
      bitcnt   = 0;
      slave_lo = 1'b0;
    end else if (scl && scl_q && sda != sda_q) begin
      if (!sda && !in_txn) begin
        in_txn    = 1'b1;
        bitcnt    = 0;
        last_rise = -1;
        rx.delete();
      end else if (sda && in_txn) begin
        in_txn = 1'b0;
        n_stop++;
      end else
        bad_change++;
    end else if (in_txn && scl && !scl_q) begin
      if (last_rise >= 0 && cyc - last_rise != SLOT)
        period_bad++;
      last_rise = cyc;
      if (bitcnt < 8) begin
        shv = {shv[6:0], sda};
        bitcnt++;
        if (bitcnt == 8)
          rx.push_back(shv);
      end else
        bitcnt = 0;
    end else if (in_txn && !scl && scl_q)
      slave_lo = (bitcnt == 8) && (rx.size() - 1 != nack_at);
    scl_q = scl;
    sda_q = sda;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_32M);
      #1;
    end
  endtask

  task automatic wait_rise(input int r0, input string tag, output bit ok);
    int k = 0;
    while (rise_cnt == r0 && k < 300) begin
      tick(1);
      k++;
    end
    ok = rise_cnt != r0;
    if (!ok) chk({tag, " busy rise timeout"}, 0, 1);
  endtask

  task automatic wait_done(input int d0, input bit toggle, input string tag, output bit ok);
    int k = 0;
    while (done_cnt == d0 && k < 5000) begin
      if (toggle) begin
        reg_addr = 8'($urandom);
        data_in  = 8'($urandom);
      end
      tick(1);
      k++;
    end
    ok = done_cnt != d0;
    if (!ok) chk({tag, " done timeout"}, 0, 1);
  endtask

  // Reference model: bytes sent stop at the first NACKed one; every slot is 4*CLK_DIV cycles
  function automatic int model_sent(input int nb);
    return nb < 3 ? nb + 1 : 3;
  endfunction
  function automatic int model_lat(input int nb);
    return SLOT * (1 + 9 * model_sent(nb) + 1);
  endfunction

  task automatic check_bytes(input logic [7:0] c, input logic [7:0] d, input int nb, input string tag);
    logic [7:0] exp_b[3];
    int n = model_sent(nb);
    exp_b[0] = 8'h78;
    exp_b[1] = c;
    exp_b[2] = d;
    chk({tag, " byte count"}, rx.size(), n);
    for (int i = 0; i < n && i < rx.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), rx[i], exp_b[i]);
    chk({tag, " scl period"}, period_bad, 0);
    chk({tag, " sda change while scl high"}, bad_change, 0);
  endtask

  task automatic run_txn(input logic [7:0] c, input logic [7:0] d, input int nb, input int lat,
                         input logic err, input bit toggle, input string tag);
    int r0 = rise_cnt, d0 = done_cnt, s0 = n_stop;
    bit ok;
    nack_at  = nb;
    reg_addr = c;
    data_in  = d;
    enable   = 1'b1;
    wait_rise(r0, tag, ok);
    enable = 1'b0;
    if (!ok) return;
    chk({tag, " ack_err held"}, ack_err, prev_err);
    wait_done(d0, toggle, tag, ok);
    if (!ok) return;
    chk({tag, " latency"}, done_cyc - rise_cyc, lat);
    chk({tag, " ack_err"}, ack_err, err);
    tick(1);
    chk({tag, " done width"}, done, 0);
    chk({tag, " stop count"}, n_stop - s0, 1);
    check_bytes(c, d, nb, tag);
    prev_err = err;
  endtask

  typedef struct {
    logic [7:0] c;
    logic [7:0] d;
    int         nb;
    int         lat;
    logic       err;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int  bad, r0, d0;
    bit  ok;
    tbl[0] = '{8'h00, 8'hAE, 3, 2320, 1'b0};
    tbl[1] = '{8'h00, 8'h12, 0, 880, 1'b1};
    tbl[2] = '{8'h40, 8'h55, 1, 1600, 1'b1};
    tbl[3] = '{8'h40, 8'hA5, 2, 2320, 1'b1};
    tbl[4] = '{8'h40, 8'h3C, 3, 2320, 1'b0};

    tick(3);
    chk("reset scl", scl, 1);
    chk("reset sda", sda, 1);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset ack_err", ack_err, 0);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (scl !== 1'b1 || sda !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ack_err !== 1'b0)
        bad++;
    end
    chk("idle 1000 cycles", bad, 0);

    for (int i = 0; i < 5; i++)
      run_txn(tbl[i].c, tbl[i].d, tbl[i].nb, tbl[i].lat, tbl[i].err, 1'b0, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      logic [7:0] c = $urandom_range(0, 1) ? 8'h40 : 8'h00;
      logic [7:0] d = 8'($urandom);
      int nb = $urandom_range(0, 5);
      if (nb > 3) nb = 3;
      run_txn(c, d, nb, model_lat(nb), nb < 3, 1'b0, $sformatf("rand%0d", i));
    end

    run_txn(8'h40, 8'h6B, 3, model_lat(3), 1'b0, 1'b1, "toggle");

    nack_at  = 3;
    reg_addr = 8'h00;
    data_in  = 8'hAE;
    enable   = 1'b1;
    r0 = rise_cnt;
    d0 = done_cnt;
    wait_rise(r0, "b2b first", ok);
    if (ok) wait_done(d0, 1'b0, "b2b first", ok);
    if (ok) begin
      chk("b2b first latency", done_cyc - rise_cyc, 2320);
      tick(1);
      reg_addr = 8'h40;
      data_in  = 8'hFF;
      r0 = rise_cnt;
      d0 = done_cnt;
      wait_rise(r0, "b2b second", ok);
      enable = 1'b0;
      if (ok) begin
        chk("b2b done to busy gap", rise_cyc - done_cyc, 81);
        wait_done(d0, 1'b0, "b2b second", ok);
        if (ok) begin
          chk("b2b ack_err", ack_err, 0);
          check_bytes(8'h40, 8'hFF, 3, "b2b second");
        end
      end
    end
    enable   = 1'b0;
    prev_err = 1'b0;
    tick(200);

    reg_addr = 8'h00;
    data_in  = 8'hC3;
    enable   = 1'b1;
    r0 = rise_cnt;
    wait_rise(r0, "abort", ok);
    enable = 1'b0;
    tick(1000);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort scl", scl, 1);
    chk("abort sda", sda, 1);
    chk("abort busy", busy, 0);
    tick(3);
    rst_n = 1'b1;
    tick(3000);
    chk("abort no done", done_cnt - d0, 0);
    prev_err = 1'b0;
    run_txn(8'h40, 8'h81, 3, model_lat(3), 1'b0, 1'b0, "after abort");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
